bit_pool_multi: RTL
===================

# bit_pool_multi

Multi-channel, parametrised successor to the single-channel TRNG bit pool. It collects sampled bits from `N_CHAN` ring-oscillator (Galois) channels into per-channel pools of `POOL_WIDTH` bits. Once every pool is complete, it drains the pools as `WORD_WIDTH`-bit words over a valid/ready stream toward the UART/host readout path. It supports one-shot and continuous capture, and an optional compiled-in von Neumann debiaser.

## Interface
Parameters:
- `N_CHAN`, 4: number of independent TRNG channels.
- `POOL_WIDTH`, 64: bits stored per channel. Must be a multiple of `WORD_WIDTH`.
- `WORD_WIDTH`, 32: output word width. Must be ≥1.

Ports:
- `clock`, in, 1: single clock. Sampling clock of the rings; all logic is on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `enable`, in, 1: high = capture session active. Low aborts and clears the block.
- `continuous`, in, 1: 1 = refill automatically after each drain. 0 = one-shot.
- `muestra_valid`, in, 1: qualifies `muestra` this cycle.
- `muestra`, in, `N_CHAN`: one sampled bit per channel.
- `full`, out, 1: all pools complete (DRAIN/DONE).
- `busy`, out, 1: state is FILL.
- `out_data`, out, `WORD_WIDTH`: current word. Zero when `out_valid` = 0.
- `out_chan`, out, `CHAN_W`: channel index of `out_data`.
- `out_valid`, out, 1: word available.
- `out_ready`, in, 1: consumer accepts.
- `out_last`, out, 1: final word of the final channel.

## Operation
- States:
  - IDLE → FILL when `enable` = 1.
  - FILL → DRAIN when every channel counter equals `POOL_WIDTH`.
  - DRAIN → FILL after the `out_last` transfer when `continuous` = 1. Counters are cleared.
  - DRAIN → DONE after the `out_last` transfer when `continuous` = 0.
  - DONE holds until `enable` = 0.
- `enable` = 0 in any state:
  - Next state is IDLE.
  - Counters, read pointer, debiaser hold registers, `full`, and `out_valid` are cleared. An in-flight word is dropped.
- FILL, raw mode: on each `muestra_valid` cycle, channel c writes `muestra[c]` to `pool[c][cnt[c]]` (LSB first) and increments `cnt[c]`. A channel whose `cnt[c]` equals `POOL_WIDTH` ignores further bits.
- Samples in IDLE, DRAIN, or DONE are ignored.
- DRAIN word order: channel 0 word 0 … channel 0 word `WPC-1`, then channel 1, and so on, where `WPC` = `POOL_WIDTH`/`WORD_WIDTH`. Word w of channel c is `pool[c][w*WORD_WIDTH +: WORD_WIDTH]`.
- Total words per drain: `N_CHAN`×`WPC`. `out_last` is high only with the final word.
- Output flags:
  - `full` = 1 in DRAIN and DONE.
  - `busy` = 1 in FILL.
  - `out_valid` = 1 in DRAIN only.
- Counter widths:
  - `cnt` is `CNT_W` = $clog2(`POOL_WIDTH`+1) bits and never exceeds `POOL_WIDTH`.
  - The read pointer wraps to 0 after `out_last`.
- Elaboration error if `POOL_WIDTH` % `WORD_WIDTH` ≠ 0 or `N_CHAN` < 1.

## Timing
- Reset (`reset_n` = 0 at an edge): state IDLE; `full`, `busy`, `out_valid`, `out_last`, `out_data`, and `out_chan` all 0; counters 0. Pool contents are don't-care.
- `enable` sampled high at edge t → `busy` = 1 after t. The first sample accepted is the one presented at edge t+1.
- The last required bit accepted at edge k → `full` = 1, `out_valid` = 1, first word on `out_data` after k, with no bubble.
- Transfer occurs on an edge with `out_valid` && `out_ready`. The next word appears after that edge, giving one word per cycle at full throughput.
- While `out_valid` && !`out_ready`: `out_data`, `out_chan`, and `out_last` are held stable.
- After the `out_last` transfer at edge m:
  - Continuous mode: `full` = 0 and `busy` = 1 after m. A sample at edge m+1 is accepted.
  - One-shot mode: `full` stays 1 and `out_valid` drops to 0.
- `enable` low at edge e: all outputs are 0 after e, regardless of `out_ready`.

## Configuration
- `BIT_POOL_VN_EN` defined: each channel has a von Neumann corrector on its accepted samples.
  - Samples are paired per channel. The first bit of a pair goes to a hold register.
  - On the second bit: pair 01 stores 0, pair 10 stores 1, pairs 00/11 store nothing.
  - Channels fill independently. FILL ends only when the slowest channel completes.
  - A pair whose first bit arrives after the channel has filled is discarded.
- Undefined: raw bits are stored and all channels fill in lockstep. No hold registers are synthesised.

## Structure
- Package `bit_pool_pkg` holds:
  - State enum typedef (IDLE, FILL, DRAIN, DONE).
  - Function or localparams for `WPC`, `CNT_W`, and `CHAN_W` = max(1, $clog2(`N_CHAN`)).
- Sub-module `bit_pool_vn_corrector`: per-channel pair logic (`clock`, `reset_n`, `clear`, `in_valid`, `in_bit`, `out_valid`, `out_bit`). It is instantiated N_CHAN times only under `BIT_POOL_VN_EN`.

## Test plan
- Raw mode, defaults, `out_ready` = 1, `muestra` = 4'b1010 every cycle for 64 cycles:
  - 8 words out.
  - Channels 0 and 2 words = 32'h0, channels 1 and 3 = 32'hFFFF_FFFF.
  - `out_last` only on word 8.
  - `full` after exactly 64 accepts.
- Backpressure: `out_ready` toggles 1,0,0,1… → each word held stable while stalled. Word order and `out_chan` sequence are 0,0,1,1,2,2,3,3.
- Continuous = 1 → after `out_last`, `busy` = 1 next cycle, a second drain of 8 words follows, and no samples are lost at the boundary.
- `enable` dropped mid-FILL at 30 bits, then re-raised → capture restarts at bit 0, the first word reflects only the new samples, and all outputs are 0 in the gap cycle.
- Reset asserted during DRAIN with `out_valid` = 1 → all outputs 0 next cycle and state IDLE.
- With `BIT_POOL_VN_EN`: channel 0 fed 0,1,1,0,0,0,1,1 repeated → stores 0,1 per 8 samples. Channel 1 fed 1,1 constantly → never completes, so `full` stays 0.

Source files
------------

// File: rtl/bit_pool_pkg.sv
// Shared types and sizing helpers for the multi-channel TRNG bit pool.
package bit_pool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Words held per channel pool.
  function automatic int unsigned calc_wpc(input int unsigned pool_width,
                                           input int unsigned word_width);
    return (word_width == 0) ? 1 : pool_width / word_width;
  endfunction

  // Counter width able to hold the value pool_width itself.
  function automatic int unsigned calc_cnt_w(input int unsigned pool_width);
    return $clog2(pool_width + 1);
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned calc_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned calc_chan_w(input int unsigned n_chan);
    return calc_idx_w(n_chan);
  endfunction

endpackage

// File: rtl/bit_pool_vn_corrector.sv
// Per-channel von Neumann pair corrector: 01 -> 0, 10 -> 1, 00/11 -> nothing.
module bit_pool_vn_corrector (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit
);

  logic have_first;
  logic first_bit;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      have_first <= 1'b0;
      first_bit  <= 1'b0;
    end else if (in_valid) begin
      have_first <= !have_first;
      if (!have_first) first_bit <= in_bit;
    end
  end

  // Output fires on the second bit of an unequal pair, in the same cycle.
  assign out_valid = in_valid && have_first && (first_bit != in_bit);
  assign out_bit   = first_bit;

endmodule

// File: rtl/bit_pool_multi.sv
// Multi-channel TRNG bit pool: fill N_CHAN pools, then drain them as words.
// Optional von Neumann debiasing per channel with BIT_POOL_VN_EN defined.
module bit_pool_multi
  import bit_pool_pkg::*;
#(
  parameter int unsigned N_CHAN     = 4,
  parameter int unsigned POOL_WIDTH = 64,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                enable,
  input  logic                                continuous,
  input  logic                                muestra_valid,
  input  logic [N_CHAN-1:0]                   muestra,
  output logic                                full,
  output logic                                busy,
  output logic [WORD_WIDTH-1:0]               out_data,
  output logic [calc_chan_w(N_CHAN)-1:0]      out_chan,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last
);

  localparam int unsigned WPC    = calc_wpc(POOL_WIDTH, WORD_WIDTH);
  localparam int unsigned CNT_W  = calc_cnt_w(POOL_WIDTH);
  localparam int unsigned CHAN_W = calc_chan_w(N_CHAN);
  localparam int unsigned TOT    = N_CHAN * WPC;
  localparam int unsigned PTR_W  = calc_idx_w(TOT);

  if (WORD_WIDTH < 1 || N_CHAN < 1 || (POOL_WIDTH % WORD_WIDTH) != 0) begin : g_bad_cfg
    $error("bit_pool_multi: invalid N_CHAN/POOL_WIDTH/WORD_WIDTH combination");
  end

  state_t                  state;
  logic [POOL_WIDTH-1:0]   pool     [N_CHAN];
  logic [POOL_WIDTH-1:0]   pool_nxt [N_CHAN];
  logic [CNT_W-1:0]        cnt      [N_CHAN];
  logic [CNT_W-1:0]        cnt_nxt  [N_CHAN];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        sel_ptr;
  logic                    sel_last;
  logic [WORD_WIDTH-1:0]   word_nxt;
  logic [WORD_WIDTH-1:0]   words    [TOT];
  logic [CHAN_W-1:0]       chan_of  [TOT];
  logic [N_CHAN-1:0]       accept;
  logic [N_CHAN-1:0]       take;
  logic [N_CHAN-1:0]       store_bit;
  logic                    all_full;

  // Samples enter a channel only while filling and until its pool is complete.
  always_comb begin
    accept = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      accept[c] = muestra_valid && (state == FILL) && (cnt[c] != CNT_W'(POOL_WIDTH));
    end
  end

`ifdef BIT_POOL_VN_EN
  for (genvar c = 0; c < N_CHAN; c++) begin : g_vn
    bit_pool_vn_corrector u_vn (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (!enable),
      .in_valid  (accept[c]),
      .in_bit    (muestra[c]),
      .out_valid (take[c]),
      .out_bit   (store_bit[c])
    );
  end
`else
  assign take      = accept;
  assign store_bit = muestra;
`endif

  // Bits shift in from the top so the first stored bit ends up at bit 0.
  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < N_CHAN; c++) begin
      pool_nxt[c] = pool[c];
      cnt_nxt[c]  = cnt[c];
      if (take[c]) begin
        pool_nxt[c] = (pool[c] >> 1) | (POOL_WIDTH'(store_bit[c]) << (POOL_WIDTH - 1));
        cnt_nxt[c]  = cnt[c] + CNT_W'(1);
      end
      if (cnt_nxt[c] != CNT_W'(POOL_WIDTH)) all_full = 1'b0;
    end
  end

  for (genvar k = 0; k < TOT; k++) begin : g_word
    assign words[k]   = pool_nxt[k / WPC][(k % WPC) * WORD_WIDTH +: WORD_WIDTH];
    assign chan_of[k] = CHAN_W'(k / WPC);
  end

  // Next word to present: first word when a drain starts, else the successor.
  always_comb begin
    sel_ptr  = (state == DRAIN) ? rd_ptr + PTR_W'(1) : '0;
    sel_last = (sel_ptr == PTR_W'(TOT - 1));
    word_nxt = words[sel_ptr];
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < N_CHAN; c++) pool[c] <= pool_nxt[c];
  end

  always_ff @(posedge clock) begin
    if (!reset_n || !enable) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      for (int c = 0; c < N_CHAN; c++) cnt[c] <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= FILL;
          busy  <= 1'b1;
        end
        FILL: begin
          for (int c = 0; c < N_CHAN; c++) cnt[c] <= cnt_nxt[c];
          if (all_full) begin
            state     <= DRAIN;
            busy      <= 1'b0;
            full      <= 1'b1;
            out_valid <= 1'b1;
            out_data  <= word_nxt;
            out_chan  <= chan_of[sel_ptr];
            out_last  <= sel_last;
            rd_ptr    <= sel_ptr;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
              out_chan  <= '0;
              rd_ptr    <= '0;
              if (continuous) begin
                state <= FILL;
                busy  <= 1'b1;
                full  <= 1'b0;
                for (int c = 0; c < N_CHAN; c++) cnt[c] <= '0;
              end else begin
                state <= DONE;
              end
            end else begin
              out_data <= word_nxt;
              out_chan <= chan_of[sel_ptr];
              out_last <= sel_last;
              rd_ptr   <= sel_ptr;
            end
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
